// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART link.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_DATA  = 2'd2,
    T_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Load-able down-counter; tick is high in the cycle before the count expires,
// so an FSM acting on tick does so exactly load_val edges after the load.
module uart_bit_timer #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;
  logic             tick_r;

  // Next count: reload wins, otherwise count down and park at zero.
  always_comb begin
    if (load) begin
      count_next_s = load_val;
    end else if (count_r != {WIDTH{1'b0}}) begin
      count_next_s = count_r - WIDTH'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Counter and registered tick.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count_r <= {WIDTH{1'b0}};
      tick_r  <= 1'b0;
    end else begin
      count_r <= count_next_s;
      tick_r  <= (count_next_s == WIDTH'(1));
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_link.sv
// Full-duplex 8N1 UART: independent RX (with one-entry holding register)
// and TX engines, each paced by its own uart_bit_timer.
module uart_link
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 rx,
  output logic                 tx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready
);

  localparam int              TW       = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0]   FULL_BIT = TW'(CLKS_PER_BIT);
  localparam logic [TW-1:0]   HALF_BIT = TW'(CLKS_PER_BIT / 2);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_meta_r, rx_sync_r, rx_prev_r;
  logic [2:0]           rx_fill_r;
  rx_state_t            rx_state_r;
  logic [2:0]           rx_bit_cnt_r;
  logic [DATA_BITS-1:0] rx_shift_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r, rx_frame_err_r, rx_overrun_r;
  logic                 rx_load_s, rx_tick_s, rx_fall_s;
  logic                 rx_good_s, rx_bad_s, rx_consume_s;
  logic [TW-1:0]        rx_load_val_s;

  tx_state_t            tx_state_r;
  logic [2:0]           tx_bit_cnt_r;
  logic [DATA_BITS-1:0] tx_shift_r;
  logic                 tx_r, tx_ready_r;
  logic                 tx_load_s, tx_tick_s, tx_accept_s;

  // Synchronizer plus fill marker: edges are only trusted once prev holds a real line sample.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
      rx_fill_r <= 3'b000;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
      rx_fill_r <= {rx_fill_r[1:0], 1'b1};
    end
  end

  assign rx_fall_s    = rx_fill_r[2] && rx_prev_r && !rx_sync_r;
  assign rx_good_s    = (rx_state_r == R_STOP) && rx_tick_s && rx_sync_r;
  assign rx_bad_s     = (rx_state_r == R_STOP) && rx_tick_s && !rx_sync_r;
  assign rx_consume_s = rx_valid_r && rx_ready;

  // RX timer reload: half a bit to the start mid-point, then whole bits.
  always_comb begin
    rx_load_s     = 1'b0;
    rx_load_val_s = FULL_BIT;
    case (rx_state_r)
      R_IDLE: begin
        if (rx_fall_s) begin
          rx_load_s     = 1'b1;
          rx_load_val_s = HALF_BIT;
        end else begin
          rx_load_s = 1'b0;
        end
      end
      R_START: begin
        if (rx_tick_s && !rx_sync_r) rx_load_s = 1'b1;
        else                         rx_load_s = 1'b0;
      end
      R_DATA: begin
        if (rx_tick_s) rx_load_s = 1'b1;
        else           rx_load_s = 1'b0;
      end
      R_STOP:  rx_load_s = 1'b0;
      default: rx_load_s = 1'b0;
    endcase
  end

  uart_bit_timer #(.WIDTH(TW)) u_rx_timer (
    .clk      (clk),
    .rst_l    (rst_l),
    .load     (rx_load_s),
    .load_val (rx_load_val_s),
    .tick     (rx_tick_s)
  );

  // RX frame FSM.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_state_r   <= R_IDLE;
      rx_bit_cnt_r <= 3'd0;
      rx_shift_r   <= {DATA_BITS{1'b0}};
    end else begin
      case (rx_state_r)
        R_IDLE: begin
          if (rx_fall_s) begin
            rx_state_r   <= R_START;
            rx_bit_cnt_r <= 3'd0;
          end
        end
        R_START: begin
          if (rx_tick_s) rx_state_r <= rx_sync_r ? R_IDLE : R_DATA;
        end
        R_DATA: begin
          if (rx_tick_s) begin
            rx_shift_r <= {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
            if (rx_bit_cnt_r == LAST_BIT) begin
              rx_state_r   <= R_STOP;
              rx_bit_cnt_r <= 3'd0;
            end else begin
              rx_bit_cnt_r <= rx_bit_cnt_r + 3'd1;
            end
          end
        end
        R_STOP: begin
          if (rx_tick_s) rx_state_r <= R_IDLE;
        end
        default: rx_state_r <= R_IDLE;
      endcase
    end
  end

  // Holding register: a new byte is accepted only into an empty or draining slot.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_data_r      <= {DATA_BITS{1'b0}};
      rx_valid_r     <= 1'b0;
      rx_frame_err_r <= 1'b0;
      rx_overrun_r   <= 1'b0;
    end else begin
      rx_frame_err_r <= rx_bad_s;
      rx_overrun_r   <= rx_good_s && rx_valid_r && !rx_ready;
      if (rx_good_s && (!rx_valid_r || rx_ready)) begin
        rx_data_r  <= rx_shift_r;
        rx_valid_r <= 1'b1;
      end else if (rx_consume_s) begin
        rx_valid_r <= 1'b0;
      end
    end
  end

  assign tx_accept_s = tx_valid && tx_ready_r;

  // TX timer reload at frame accept and at every bit boundary except the stop end.
  always_comb begin
    tx_load_s = 1'b0;
    if (tx_accept_s) begin
      tx_load_s = 1'b1;
    end else if (tx_tick_s && (tx_state_r == T_START || tx_state_r == T_DATA)) begin
      tx_load_s = 1'b1;
    end else begin
      tx_load_s = 1'b0;
    end
  end

  uart_bit_timer #(.WIDTH(TW)) u_tx_timer (
    .clk      (clk),
    .rst_l    (rst_l),
    .load     (tx_load_s),
    .load_val (FULL_BIT),
    .tick     (tx_tick_s)
  );

  // TX frame FSM; the byte is captured at accept so later tx_data changes are ignored.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      tx_state_r   <= T_IDLE;
      tx_bit_cnt_r <= 3'd0;
      tx_shift_r   <= {DATA_BITS{1'b0}};
      tx_r         <= 1'b1;
      tx_ready_r   <= 1'b1;
    end else begin
      case (tx_state_r)
        T_IDLE: begin
          if (tx_accept_s) begin
            tx_shift_r   <= tx_data;
            tx_r         <= 1'b0;
            tx_bit_cnt_r <= 3'd0;
            tx_state_r   <= T_START;
            tx_ready_r   <= 1'b0;
          end
        end
        T_START: begin
          if (tx_tick_s) begin
            tx_r       <= tx_shift_r[0];
            tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
            tx_state_r <= T_DATA;
          end
        end
        T_DATA: begin
          if (tx_tick_s) begin
            if (tx_bit_cnt_r == LAST_BIT) begin
              tx_r       <= 1'b1;
              tx_state_r <= T_STOP;
            end else begin
              tx_r         <= tx_shift_r[0];
              tx_shift_r   <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
              tx_bit_cnt_r <= tx_bit_cnt_r + 3'd1;
            end
          end
        end
        T_STOP: begin
          if (tx_tick_s) begin
            tx_state_r <= T_IDLE;
            tx_ready_r <= 1'b1;
          end
        end
        default: begin
          tx_state_r <= T_IDLE;
          tx_ready_r <= 1'b1;
          tx_r       <= 1'b1;
        end
      endcase
    end
  end

  assign tx           = tx_r;
  assign tx_ready     = tx_ready_r;
  assign rx_data      = rx_data_r;
  assign rx_valid     = rx_valid_r;
  assign rx_frame_err = rx_frame_err_r;
  assign rx_overrun   = rx_overrun_r;

endmodule

// File: tb/tb_uart_link.sv
// Self-checking bench for uart_link at 16 clocks per bit, scoreboard-driven.
module tb_uart_link;

  localparam int CPB = 16;

  logic       clk      = 1'b0;
  logic       rst_l    = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx, tx_ready, rx_valid, rx_frame_err, rx_overrun;
  logic [7:0] rx_data;

  int checks   = 0;
  int errors   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];

  uart_link #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .rx           (rx),
    .tx           (tx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_frame_err === 1'b1) ferr_cnt++;
    if (rx_overrun === 1'b1) ovr_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  // Drive one 8N1 frame starting at a negedge; optionally pulse rx_ready on the stop-sample edge.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input bit ready_at_done);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      for (int c = 0; c < CPB; c++) begin
        if (ready_at_done && i == 9 && c == 10) rx_ready = 1'b1;
        if (ready_at_done && i == 9 && c == 11) rx_ready = 1'b0;
        @(negedge clk);
      end
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (rx_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b, required 1", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b, required 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h, required 00", rx_data); end
    checks++; if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: frame_err=%b overrun=%b, required 0 0", rx_frame_err, rx_overrun);
    end
    rst_l = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_rx_basic();
    int fb, ob; bit ok; logic [7:0] exp;
    fb = ferr_cnt; ob = ovr_cnt;
    rx_exp_q.push_back(8'hA5);
    send_rx(8'hA5, 1'b1, 1'b0);
    wait_valid(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rx_a5_valid: rx_valid=%b, required 1 within 16 cycles of stop mid-point", rx_valid); end
    exp = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hxx;
    checks++; if (rx_data !== exp) begin errors++; $display("FAIL rx_a5_data: got %h, required %h", rx_data, exp); end
    checks++; if (ferr_cnt != fb || ovr_cnt != ob) begin
      errors++; $display("FAIL rx_a5_pulses: frame_err=%0d overrun=%0d, required 0 0", ferr_cnt - fb, ovr_cnt - ob);
    end
    pulse_ready();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_a5_consume: rx_valid=%b, required 0", rx_valid); end
  endtask

  task automatic test_rx_glitch();
    int fb; bit ok; logic [7:0] exp;
    fb = ferr_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (rx_valid !== 1'b0 || ferr_cnt != fb) begin
      errors++; $display("FAIL rx_glitch: rx_valid=%b frame_err=%0d, required 0 0", rx_valid, ferr_cnt - fb);
    end
    rx_exp_q.push_back(8'h96);
    send_rx(8'h96, 1'b1, 1'b0);
    wait_valid(4, ok);
    exp = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hxx;
    checks++; if (!ok || rx_data !== exp) begin
      errors++; $display("FAIL rx_after_glitch: valid=%b data=%h, required 1 %h", rx_valid, rx_data, exp);
    end
    pulse_ready();
  endtask

  task automatic test_rx_frame_err();
    int fb, ob;
    fb = ferr_cnt; ob = ovr_cnt;
    send_rx(8'h3C, 1'b0, 1'b0);
    repeat (16) @(negedge clk);
    checks++; if (ferr_cnt - fb != 1) begin errors++; $display("FAIL rx_frame_err_count: got %0d pulses, required 1", ferr_cnt - fb); end
    checks++; if (rx_valid !== 1'b0 || ovr_cnt != ob) begin
      errors++; $display("FAIL rx_frame_err_valid: rx_valid=%b overrun=%0d, required 0 0", rx_valid, ovr_cnt - ob);
    end
  endtask

  task automatic test_rx_overrun();
    int ob; bit ok; logic [7:0] exp;
    ob = ovr_cnt;
    rx_exp_q.push_back(8'h11);
    send_rx(8'h11, 1'b1, 1'b0);
    send_rx(8'h22, 1'b1, 1'b0);
    checks++; if (ovr_cnt - ob != 1) begin errors++; $display("FAIL rx_overrun_count: got %0d pulses, required 1", ovr_cnt - ob); end
    exp = (rx_exp_q.size() > 0) ? rx_exp_q[0] : 8'hxx;
    checks++; if (rx_valid !== 1'b1 || rx_data !== exp) begin
      errors++; $display("FAIL rx_overrun_keep: valid=%b data=%h, required 1 %h", rx_valid, rx_data, exp);
    end
    // 0x11 is consumed on the very edge that 0x22 completes.
    ob = ovr_cnt;
    rx_exp_q.push_back(8'h22);
    send_rx(8'h22, 1'b1, 1'b1);
    if (rx_exp_q.size() > 0) void'(rx_exp_q.pop_front());
    checks++; if (ovr_cnt != ob) begin errors++; $display("FAIL rx_same_cycle_overrun: got %0d pulses, required 0", ovr_cnt - ob); end
    wait_valid(0, ok);
    exp = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hxx;
    checks++; if (!ok || rx_data !== exp) begin
      errors++; $display("FAIL rx_same_cycle_load: valid=%b data=%h, required 1 %h", rx_valid, rx_data, exp);
    end
    pulse_ready();
  endtask

  task automatic test_tx_back_to_back();
    logic [9:0] f; logic [7:0] b; int low, bad_at; logic bad_v;
    @(negedge clk);
    tx_data = 8'h5A; tx_valid = 1'b1;
    tx_exp_q.push_back(8'h5A);
    for (int fr = 0; fr < 2; fr++) begin
      b = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'hxx;
      f = {1'b1, b, 1'b0};
      low = 0; bad_at = -1; bad_v = 1'b0;
      for (int i = 0; i < 10 * CPB; i++) begin
        @(negedge clk);
        if (fr == 0 && i == 40) begin tx_data = 8'hC3; tx_exp_q.push_back(8'hC3); end
        if (fr == 1 && i == 0) tx_valid = 1'b0;
        if (tx_ready === 1'b0) low++;
        if (tx !== f[i / CPB] && bad_at < 0) begin bad_at = i; bad_v = tx; end
      end
      checks++; if (bad_at >= 0) begin
        errors++; $display("FAIL tx_wave_%0d: cycle %0d tx=%b, required %b (byte %h)", fr, bad_at, bad_v, f[bad_at / CPB], b);
      end
      checks++; if (low != 10 * CPB) begin errors++; $display("FAIL tx_ready_low_%0d: low %0d cycles, required %0d", fr, low, 10 * CPB); end
      @(negedge clk);
      checks++; if (tx_ready !== 1'b1 || tx !== 1'b1) begin
        errors++; $display("FAIL tx_ready_back_%0d: tx_ready=%b tx=%b, required 1 1", fr, tx_ready, tx);
      end
    end
    repeat (20) @(negedge clk);
    checks++; if (tx !== 1'b1 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL tx_idle_after: tx=%b tx_ready=%b, required 1 1", tx, tx_ready);
    end
  endtask

  task automatic test_reset_midframe();
    int fb; bit ok; bit tx_low; logic [7:0] exp;
    rx_exp_q.push_back(8'h5C);
    send_rx(8'h5C, 1'b1, 1'b0);
    tx_data = 8'h81; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    rx = 1'b0;
    repeat (50) @(negedge clk);
    rst_l = 1'b0;
    #1;
    rx_exp_q.delete();
    checks++; if (tx !== 1'b1 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_tx: tx=%b tx_ready=%b, required 1 1", tx, tx_ready);
    end
    checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      errors++; $display("FAIL midreset_rx: valid=%b data=%h, required 0 00", rx_valid, rx_data);
    end
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    fb = ferr_cnt; tx_low = 1'b0;
    for (int i = 0; i < 220; i++) begin
      if (i == 40) rx = 1'b1;
      @(negedge clk);
      if (tx !== 1'b1) tx_low = 1'b1;
    end
    checks++; if (rx_valid !== 1'b0 || ferr_cnt != fb) begin
      errors++; $display("FAIL low_line_after_reset: valid=%b frame_err=%0d, required 0 0", rx_valid, ferr_cnt - fb);
    end
    checks++; if (tx_low) begin errors++; $display("FAIL tx_after_reset: tx went low, required idle 1"); end
    rx_exp_q.push_back(8'hFF);
    send_rx(8'hFF, 1'b1, 1'b0);
    wait_valid(4, ok);
    exp = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hxx;
    checks++; if (!ok || rx_data !== exp) begin
      errors++; $display("FAIL rx_ff_after_reset: valid=%b data=%h, required 1 %h", rx_valid, rx_data, exp);
    end
    pulse_ready();
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_rx_glitch();
    test_rx_frame_err();
    test_rx_overrun();
    test_tx_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
